// File: rtl/amp_pwr_seq_pkg.sv
// Shared types and constants for the amplifier power/config sequencer.
// Contents: state encoding, script entry struct, script length, device address.
package amp_pwr_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PWR_WAIT  = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_MUTED     = 3'd4,
        ST_PLAY      = 3'd5,
        ST_FAULT     = 3'd6
    } amp_seq_state_t;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } amp_seq_cmd_t;

    localparam int         AMP_SEQ_NUM_CMDS = 4;
    localparam logic [6:0] AMP_DEV_ADDR     = 7'h2C;

endpackage

// File: rtl/amp_pwr_seq_if.sv
// Byte-write command port between the sequencer and the amp I2C master.
// master: cmd_valid/dev/reg/data out, ready/done/nack in. slave: mirror.
interface amp_pwr_seq_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_data;
    logic       cmd_done;
    logic       cmd_nack;

    modport master (
        output cmd_valid, cmd_dev, cmd_reg, cmd_data,
        input  cmd_ready, cmd_done, cmd_nack
    );

    modport slave (
        input  cmd_valid, cmd_dev, cmd_reg, cmd_data,
        output cmd_ready, cmd_done, cmd_nack
    );

endinterface

// File: rtl/amp_pwr_seq_rom.sv
// Fixed amp register script: soft reset, clock config, volume, output mode.
// Ports: idx_i (script index), cmd_o (register/data pair, zero past the end).
module amp_seq_rom
    import amp_pwr_seq_pkg::*;
#(
    parameter int NUM_CMDS = AMP_SEQ_NUM_CMDS
) (
    input  logic [3:0]   idx_i,
    output amp_seq_cmd_t cmd_o
);

    always_comb begin
        cmd_o = '0;
        if (32'(idx_i) < NUM_CMDS) begin
            case (idx_i)
                4'd0:    cmd_o = '{reg_addr: 8'h00, data: 8'h01};
                4'd1:    cmd_o = '{reg_addr: 8'h02, data: 8'h10};
                4'd2:    cmd_o = '{reg_addr: 8'h03, data: 8'h30};
                4'd3:    cmd_o = '{reg_addr: 8'h04, data: 8'h02};
                default: cmd_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/amp_pwr_seq.sv
// Amp power-up sequencer: enable, settle, write register script, unmute on lock.
// Ports: clk, resetb, ena, restart, rx_lock, cmd (I2C master port),
//        amp_nenable, amp_nmute, seq_state, fault. All outputs registered.
module amp_pwr_seq #(
    parameter int         PWR_DELAY_CYC = 1200,
    parameter int         LOCK_CYC      = 4096,
    parameter int         RETRY_MAX     = 3,
    parameter int         NUM_CMDS      = 4,
    parameter logic [6:0] AMP_DEV_ADDR  = 7'h2C
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic                 ena,
    input  logic                 restart,
    input  logic                 rx_lock,
    amp_pwr_seq_if.master        cmd,
    output logic                 amp_nenable,
    output logic                 amp_nmute,
    output logic [2:0]           seq_state,
    output logic                 fault
);
    import amp_pwr_seq_pkg::*;

    localparam int DW = (PWR_DELAY_CYC > 1) ? $clog2(PWR_DELAY_CYC) : 1;
    localparam int LW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
    localparam logic [2:0] S_PWR   = 3'(ST_PWR_WAIT);
    localparam logic [2:0] S_ISSUE = 3'(ST_ISSUE);
    localparam logic [2:0] S_WAIT  = 3'(ST_WAIT_DONE);
    localparam logic [2:0] S_MUTED = 3'(ST_MUTED);
    localparam logic [2:0] S_PLAY  = 3'(ST_PLAY);
    localparam logic [2:0] S_FAULT = 3'(ST_FAULT);

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [RW-1:0] rty_q, rty_d;
    logic          valid_q, valid_d;
    logic [6:0]    dev_q, dev_d;
    logic [7:0]    reg_q, reg_d;
    logic [7:0]    data_q, data_d;
    logic          nen_q, nen_d;
    logic          nmute_q, nmute_d;
    logic          fault_q, fault_d;
    logic          rst_hit;
    amp_seq_cmd_t  rom_cmd;

    amp_seq_rom #(
        .NUM_CMDS (NUM_CMDS)
    ) u_rom (
        .idx_i (idx_q),
        .cmd_o (rom_cmd)
    );

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        lcnt_d  = lcnt_q;
        idx_d   = idx_q;
        rty_d   = rty_q;
        valid_d = valid_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        data_d  = data_q;
        fault_d = fault_q;
        rst_hit = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ena) begin
                    state_d = S_PWR;
                    dcnt_d  = '0;
                    idx_d   = '0;
                    rty_d   = '0;
                end
            end
            S_PWR: begin
                if (dcnt_q == DW'(PWR_DELAY_CYC - 1)) begin
                    state_d = S_ISSUE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_ISSUE: begin
                // First ISSUE cycle latches the entry; valid follows a cycle later.
                if (!valid_q) begin
                    valid_d = 1'b1;
                    dev_d   = AMP_DEV_ADDR;
                    reg_d   = rom_cmd.reg_addr;
                    data_d  = rom_cmd.data;
                end else if (cmd.cmd_ready) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cmd.cmd_done) begin
                    if (!cmd.cmd_nack) begin
                        rty_d = '0;
                        if (idx_q == 4'(NUM_CMDS - 1)) begin
                            state_d = S_MUTED;
                            lcnt_d  = '0;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_ISSUE;
                        end
                    end else if (rty_q == RW'(RETRY_MAX)) begin
                        state_d = S_FAULT;
                    end else begin
                        rty_d   = rty_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_MUTED: begin
                if (!rx_lock) begin
                    lcnt_d = '0;
                end else if (lcnt_q == LW'(LOCK_CYC - 1)) begin
                    state_d = S_PLAY;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            S_PLAY: begin
                if (!rx_lock) begin
                    state_d = S_MUTED;
                    lcnt_d  = '0;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disable and restart override whatever the FSM decided above.
        if (!ena) begin
            state_d = S_IDLE;
            dcnt_d  = '0;
            lcnt_d  = '0;
            idx_d   = '0;
            rty_d   = '0;
            valid_d = 1'b0;
        end else if (restart && (state_q != S_IDLE)) begin
            state_d = S_PWR;
            dcnt_d  = '0;
            lcnt_d  = '0;
            idx_d   = '0;
            rty_d   = '0;
            valid_d = 1'b0;
            fault_d = 1'b0;
            rst_hit = 1'b1;
        end

        if (state_d == S_FAULT) begin
            fault_d = 1'b1;
        end

        // Pins follow the next state so they change on the transition edge.
        nen_d   = rst_hit || (state_d == S_IDLE) || (state_d == S_FAULT);
        nmute_d = (state_d == S_PLAY);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            dcnt_q  <= '0;
            lcnt_q  <= '0;
            idx_q   <= '0;
            rty_q   <= '0;
            valid_q <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            data_q  <= '0;
            nen_q   <= 1'b1;
            nmute_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            lcnt_q  <= lcnt_d;
            idx_q   <= idx_d;
            rty_q   <= rty_d;
            valid_q <= valid_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            nen_q   <= nen_d;
            nmute_q <= nmute_d;
            fault_q <= fault_d;
        end
    end

    assign cmd.cmd_valid = valid_q;
    assign cmd.cmd_dev   = dev_q;
    assign cmd.cmd_reg   = reg_q;
    assign cmd.cmd_data  = data_q;
    assign amp_nenable   = nen_q;
    assign amp_nmute     = nmute_q;
    assign seq_state     = state_q;
    assign fault         = fault_q;

endmodule

// File: tb/tb_amp_pwr_seq.sv
// Self-checking bench for amp_pwr_seq with an I2C-master responder and
// a scoreboard of expected script writes.
module tb_amp_pwr_seq;

    localparam int PWR      = 1200;
    localparam int LOCK     = 4096;
    localparam int WAIT_MAX = 2000;
    localparam logic [29:0] RST_VEC =
        {1'b0, 7'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0};

    logic       clk = 1'b0;
    logic       resetb;
    logic       ena;
    logic       restart;
    logic       rx_lock;
    logic       amp_nenable;
    logic       amp_nmute;
    logic [2:0] seq_state;
    logic       fault;
    logic [29:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] sb [$];
    logic [15:0] rom_exp [4];

    amp_pwr_seq_if bus ();

    amp_pwr_seq dut (
        .clk         (clk),
        .resetb      (resetb),
        .ena         (ena),
        .restart     (restart),
        .rx_lock     (rx_lock),
        .cmd         (bus),
        .amp_nenable (amp_nenable),
        .amp_nmute   (amp_nmute),
        .seq_state   (seq_state),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    assign obs = {bus.cmd_valid, bus.cmd_dev, bus.cmd_reg, bus.cmd_data,
                  amp_nenable, amp_nmute, seq_state, fault};

    task automatic tick();
        @(negedge clk);
    endtask

    // I2C master model: waits for a command, scoreboards it, accepts it
    // after dly cycles, then completes it after done_dly cycles (<0: never).
    task automatic serve(input int dly, input logic nk, input int done_dly);
        int n;
        logic [15:0] exp_v;
        logic [15:0] snap;
        n = 0;
        while (bus.cmd_valid !== 1'b1 && n < WAIT_MAX) begin
            tick();
            n++;
        end
        n_tests++;
        if (bus.cmd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL serve_timeout valid=%b want=1", bus.cmd_valid);
            return;
        end
        exp_v = 16'hxxxx;
        if (sb.size() != 0) exp_v = sb.pop_front();
        n_tests++;
        if ({bus.cmd_dev, bus.cmd_reg, bus.cmd_data} !== {7'h2C, exp_v}) begin
            n_fail++;
            $display("FAIL cmd_fields got=%h/%h/%h want=2c/%h",
                     bus.cmd_dev, bus.cmd_reg, bus.cmd_data, exp_v);
        end
        snap = {bus.cmd_reg, bus.cmd_data};
        for (int i = 0; i < dly; i++) begin
            tick();
            n_tests++;
            if ({bus.cmd_valid, bus.cmd_reg, bus.cmd_data} !== {1'b1, snap}) begin
                n_fail++;
                $display("FAIL cmd_stable got=%b/%h/%h want=1/%h",
                         bus.cmd_valid, bus.cmd_reg, bus.cmd_data, snap);
            end
        end
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        n_tests++;
        if ({bus.cmd_valid, seq_state} !== {1'b0, 3'd3}) begin
            n_fail++;
            $display("FAIL accept valid/state got=%b/%0d want=0/3",
                     bus.cmd_valid, seq_state);
        end
        if (done_dly >= 0) begin
            repeat (done_dly) tick();
            bus.cmd_done = 1'b1;
            bus.cmd_nack = nk;
            tick();
            bus.cmd_done = 1'b0;
            bus.cmd_nack = 1'b0;
        end
    endtask

    task automatic do_reset();
        resetb        = 1'b0;
        ena           = 1'b0;
        restart       = 1'b0;
        rx_lock       = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.cmd_done  = 1'b0;
        bus.cmd_nack  = 1'b0;
        repeat (3) tick();
        resetb = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (obs !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_state got=%h want=%h", obs, RST_VEC);
        end
    endtask

    task automatic test_enable();
        int n;
        ena = 1'b1;
        tick();
        n_tests++;
        if ({amp_nenable, seq_state} !== {1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL enable nen/state got=%b/%0d want=0/1",
                     amp_nenable, seq_state);
        end
        n = 0;
        while (bus.cmd_valid !== 1'b1 && n < WAIT_MAX) begin
            tick();
            n++;
        end
        n_tests++;
        if (n != PWR + 1) begin
            n_fail++;
            $display("FAIL pwr_delay got=%0d want=%0d", n, PWR + 1);
        end
        sb.push_back(rom_exp[0]);
        serve(3, 1'b0, 2);
    endtask

    task automatic test_full_script();
        for (int k = 1; k < 4; k++) begin
            sb.push_back(rom_exp[k]);
            serve(3, 1'b0, 2);
        end
        n_tests++;
        if ({seq_state, amp_nmute, amp_nenable} !== {3'd4, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL script_end state/nmute/nen got=%0d/%b/%b want=4/0/0",
                     seq_state, amp_nmute, amp_nenable);
        end
    endtask

    task automatic test_lock();
        int n;
        logic rose;
        rose    = 1'b0;
        rx_lock = 1'b1;
        repeat (LOCK - 1) begin
            tick();
            if (amp_nmute !== 1'b0) rose = 1'b1;
        end
        n_tests++;
        if ({rose, seq_state} !== {1'b0, 3'd4}) begin
            n_fail++;
            $display("FAIL lock_short rose/state got=%b/%0d want=0/4",
                     rose, seq_state);
        end
        rx_lock = 1'b0;
        tick();
        rx_lock = 1'b1;
        n = 0;
        while (amp_nmute !== 1'b1 && n < LOCK + 100) begin
            tick();
            n++;
        end
        n_tests++;
        if (n != LOCK || seq_state !== 3'd5) begin
            n_fail++;
            $display("FAIL lock_run cycles/state got=%0d/%0d want=%0d/5",
                     n, seq_state, LOCK);
        end
        rx_lock = 1'b0;
        tick();
        n_tests++;
        if ({amp_nmute, seq_state} !== {1'b0, 3'd4}) begin
            n_fail++;
            $display("FAIL unlock nmute/state got=%b/%0d want=0/4",
                     amp_nmute, seq_state);
        end
    endtask

    task automatic test_nack_retry();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_tests++;
        if ({amp_nenable, seq_state} !== {1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL restart_pulse nen/state got=%b/%0d want=1/1",
                     amp_nenable, seq_state);
        end
        tick();
        n_tests++;
        if (amp_nenable !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_nen got=%b want=0", amp_nenable);
        end
        for (int k = 0; k < 2; k++) begin
            sb.push_back(rom_exp[k]);
            serve(0, 1'b0, 1);
        end
        for (int r = 0; r < 3; r++) begin
            sb.push_back(rom_exp[2]);
            serve(1, (r < 2), 1);
        end
        sb.push_back(rom_exp[3]);
        serve(0, 1'b0, 1);
        n_tests++;
        if ({seq_state, fault, sb.size() == 0} !== {3'd4, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL retry_done state/fault/sb got=%0d/%b/%0d want=4/0/0",
                     seq_state, fault, sb.size());
        end
    endtask

    task automatic test_fault();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sb.push_back(rom_exp[k]);
            serve(0, 1'b0, 1);
        end
        for (int r = 0; r < 4; r++) begin
            sb.push_back(rom_exp[2]);
            serve(0, 1'b1, 1);
        end
        n_tests++;
        if ({fault, amp_nenable, amp_nmute, seq_state} !== {1'b1, 1'b1, 1'b0, 3'd6}) begin
            n_fail++;
            $display("FAIL fault_entry f/nen/nmute/state got=%b/%b/%b/%0d want=1/1/0/6",
                     fault, amp_nenable, amp_nmute, seq_state);
        end
        repeat (5) tick();
        n_tests++;
        if ({fault, seq_state, bus.cmd_valid} !== {1'b1, 3'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL fault_hold f/state/valid got=%b/%0d/%b want=1/6/0",
                     fault, seq_state, bus.cmd_valid);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_tests++;
        if ({fault, seq_state} !== {1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL fault_restart f/state got=%b/%0d want=0/1",
                     fault, seq_state);
        end
    endtask

    task automatic test_disable();
        int n;
        sb.push_back(rom_exp[0]);
        serve(1, 1'b0, -1);
        ena = 1'b0;
        tick();
        n_tests++;
        if ({seq_state, amp_nenable, bus.cmd_valid} !== {3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL disable state/nen/valid got=%0d/%b/%b want=0/1/0",
                     seq_state, amp_nenable, bus.cmd_valid);
        end
        bus.cmd_done = 1'b1;
        tick();
        bus.cmd_done = 1'b0;
        tick();
        n_tests++;
        if ({seq_state, amp_nenable, fault} !== {3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL late_done state/nen/fault got=%0d/%b/%b want=0/1/0",
                     seq_state, amp_nenable, fault);
        end
        ena = 1'b1;
        tick();
        n_tests++;
        if (seq_state !== 3'd1) begin
            n_fail++;
            $display("FAIL reenable state got=%0d want=1", seq_state);
        end
        sb.push_back(rom_exp[0]);
        serve(0, 1'b0, 1);
        n = 0;
        while (bus.cmd_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        ena = 1'b0;
        tick();
        n_tests++;
        if ({n < 20, bus.cmd_valid, seq_state} !== {1'b1, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL abandon seen/valid/state got=%b/%b/%0d want=1/0/0",
                     (n < 20), bus.cmd_valid, seq_state);
        end
    endtask

    task automatic test_async_reset();
        int n;
        ena = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sb.push_back(rom_exp[k]);
            serve(0, 1'b0, 0);
        end
        rx_lock = 1'b1;
        n = 0;
        while (amp_nmute !== 1'b1 && n < LOCK + 100) begin
            tick();
            n++;
        end
        n_tests++;
        if ({amp_nmute, seq_state} !== {1'b1, 3'd5}) begin
            n_fail++;
            $display("FAIL reach_play nmute/state got=%b/%0d want=1/5",
                     amp_nmute, seq_state);
        end
        tick();
        #2 resetb = 1'b0;
        #1;
        n_tests++;
        if (obs !== RST_VEC) begin
            n_fail++;
            $display("FAIL async_reset got=%h want=%h", obs, RST_VEC);
        end
        ena     = 1'b0;
        rx_lock = 1'b0;
        tick();
        resetb = 1'b1;
        tick();
    endtask

    initial begin
        rom_exp[0] = 16'h0001;
        rom_exp[1] = 16'h0210;
        rom_exp[2] = 16'h0330;
        rom_exp[3] = 16'h0402;
        test_reset();
        test_enable();
        test_full_script();
        test_lock();
        test_nack_retry();
        test_fault();
        test_disable();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/amp_pwr_seq.md
Name: amp_pwr_seq

Overview:
- Power-up/configuration sequencer for the external I2S amplifier.
- After `ena`, it releases `amp_nenable`, waits a settle time, then writes a fixed register script to the amp through the byte-write command port of the amp I2C master.
- Afterwards it holds `amp_nmute` low until the SPDIF receiver reports stable lock.
- It sits between `amp_if`'s I2C master / `rx_lock` status and the amp control pins; status is exposed to the register bank.

Parameters:
- PWR_DELAY_CYC, 1200, cycles between `amp_nenable` falling and the first I2C write.
- LOCK_CYC, 4096, consecutive `rx_lock`-high cycles required before unmute.
- RETRY_MAX, 3, retries per script entry after a NACK before FAULT.
- NUM_CMDS, 4, number of script entries (1..16).
- AMP_DEV_ADDR, 7'h2C, 7-bit amp I2C device address.

Ports:
- clk  in  1  system clock
- resetb  in  1  async active-low reset
- ena  in  1  top-level enable; low forces shutdown
- restart  in  1  one-cycle pulse: rerun the sequence from PWR_WAIT
- rx_lock  in  1  SPDIF receiver lock status (synchronous to clk)
- cmd_valid  out  1  I2C write command valid
- cmd_ready  in  1  I2C master accepts the command
- cmd_dev  out  7  device address (AMP_DEV_ADDR)
- cmd_reg  out  8  amp register address
- cmd_data  out  8  amp register data
- cmd_done  in  1  one-cycle pulse: transfer finished
- cmd_nack  in  1  valid with cmd_done: slave NACKed
- amp_nenable  out  1  amp enable, active low
- amp_nmute  out  1  amp mute, active low
- seq_state  out  3  current state encoding, for the register bank
- fault  out  1  sticky: retries exhausted

Behaviour:
- Reset: async active-low; all flops clear.
  - Reset values: `cmd_valid`=0, `cmd_dev`/`cmd_reg`/`cmd_data`=0, `amp_nenable`=1, `amp_nmute`=0, `seq_state`=IDLE(0), `fault`=0.
- States:
  - IDLE=0, PWR_WAIT=1, ISSUE=2, WAIT_DONE=3, MUTED=4, PLAY=5, FAULT=6.
- IDLE:
  - `amp_nenable`=1, `amp_nmute`=0.
  - `ena`=1 -> PWR_WAIT; the delay counter is loaded with 0 and the script index with 0.
- PWR_WAIT:
  - `amp_nenable`=0.
  - Counter increments each cycle; when counter==PWR_DELAY_CYC-1 -> ISSUE.
  - First `cmd_valid` therefore appears exactly PWR_DELAY_CYC+1 cycles after `amp_nenable` falls.
- ISSUE:
  - `cmd_valid`=1, with `cmd_reg`/`cmd_data` taken from the script entry at the current index.
  - Fields are stable while `cmd_valid`=1 and `cmd_ready`=0.
  - Handshake on `cmd_valid`&&`cmd_ready`: `cmd_valid` drops the next cycle -> WAIT_DONE.
- WAIT_DONE:
  - On `cmd_done` with `cmd_nack`=0: clear the retry count; if index==NUM_CMDS-1 -> MUTED, else index+1 -> ISSUE.
  - On `cmd_done` with `cmd_nack`=1: if retry==RETRY_MAX -> FAULT, else retry+1 -> ISSUE with the same entry.
  - A `cmd_done` outside WAIT_DONE is ignored.
- MUTED:
  - `amp_nmute`=0; the lock counter counts while `rx_lock`=1 and clears to 0 on any `rx_lock`=0.
  - Lock counter reaching LOCK_CYC-1 -> PLAY.
- PLAY:
  - `amp_nmute`=1.
  - `rx_lock`=0 -> MUTED; `amp_nmute` goes low on the next clock edge and the lock counter clears.
- FAULT:
  - `fault`=1 (sticky), `amp_nenable`=1, `amp_nmute`=0.
  - Leaves only on `restart` or `ena` low; `fault` clears only on `restart` or reset.
- `ena`=0 in any state:
  - Next state is IDLE and all counters clear.
  - If an I2C command was handshaken but not yet done, the sequencer still goes to IDLE; the late `cmd_done` is ignored.
  - `cmd_valid` drops immediately, so an unaccepted command is abandoned.
- `restart` when `ena`=1, any state other than IDLE:
  - -> PWR_WAIT with index/retry/counters cleared and `amp_nenable` pulsed high for one cycle.
  - `restart` has priority over `cmd_done` in the same cycle.
- Width rules:
  - Delay counter: clog2(PWR_DELAY_CYC) bits. Lock counter: clog2(LOCK_CYC) bits.
  - Neither counter wraps; both saturate at terminal count.
  - Index: 4 bits.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- toi2s_pkg additions:
  - typedef enum amp_seq_state_t (3-bit, values above);
  - struct amp_seq_cmd_t {reg[7:0], data[7:0]};
  - constants AMP_SEQ_NUM_CMDS and AMP_DEV_ADDR.
- Sub-module amp_seq_rom: combinational index -> amp_seq_cmd_t script table (soft-reset, clock config, volume, output mode), NUM_CMDS entries.
- amp_cfg register bank fields:
  - restart bit;
  - status readback of `seq_state` and `fault`.

Test Plan:
- Reset and enable: reset, `ena`=1 -> `amp_nenable` falls 1 cycle after `ena`; `cmd_valid` rises PWR_DELAY_CYC+1 cycles later with `cmd_dev`=0x2C and `cmd_reg`/`cmd_data`=rom[0].
- Full script: with `cmd_ready` delayed 3 cycles each time, fields stay stable until accept; 4 commands go out in ROM order; then `seq_state`=4 and `amp_nmute`=0.
- Lock handling: hold `rx_lock` high for 4095 cycles, glitch low, then high for 4096 cycles -> `amp_nmute` rises only after the second run; drop `rx_lock` -> `amp_nmute`=0 next cycle, `seq_state`=4.
- NACK retry: NACK entry 2 twice then ACK -> entry 2 issued 3 times, sequence completes; NACK 4 times -> `fault`=1, `amp_nenable`=1, `seq_state`=6; then `restart` -> `fault`=0 and PWR_WAIT.
- Disable mid-transfer: `ena`=0 in WAIT_DONE -> IDLE next cycle, `amp_nenable`=1; a late `cmd_done` changes nothing; `ena`=1 reruns from entry 0.
- Async reset: assert `resetb` low mid-PLAY -> all outputs at reset values immediately, before the next clk edge.
